// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

    localparam int          DEPTH_DEF        = 2;
    localparam int          STARVE_LIMIT_DEF = 4;
    localparam logic [3:0]  ADDR_PC          = 4'hF;

    typedef struct packed {
        logic        valid;
        logic [3:0]  wa;
        logic [31:0] wd;
    } q_entry_t;

endpackage

// File: rtl/rf_wr_queue.sv
// Pending MDU result FIFO with squash-by-address and a pending-register mask.
// Latency: push visible at head and in pend_mask the cycle after the push.
// Backpressure: full from registered count only; caller must not push when full or pop when empty.
module rf_wr_queue
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_vld,
    input  q_entry_t    push_dat,
    input  logic        pop,
    input  logic        squash_vld,
    input  logic [3:0]  squash_wa,
    output logic        full,
    output logic        empty,
    output q_entry_t    head_dat,
    output logic [15:0] pend_mask
);

    localparam int AW = $clog2(DEPTH);

    q_entry_t        mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     cnt;
    logic [AW-1:0]   idx;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            // The push slot is never occupied, so the push write may safely follow the squash loop.
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_vld && mem[i].valid && (mem[i].wa == squash_wa)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (AW+1)'(push_vld) - (AW+1)'(pop);
        end
    end

    always_comb begin
        pend_mask = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if (((AW+1)'(k) < cnt) && mem[idx].valid) begin
                pend_mask[mem[idx].wa] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between writeback and queued MDU results; address 15 goes to the PC.
// Latency: writeback combinational; MDU result written no earlier than the cycle after acceptance.
// Backpressure: md_ready=!full (registered); wb_stall when a starved queue head is forced.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [3:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        md_valid,
    input  logic [3:0]  md_wa,
    input  logic [31:0] md_wd,
    output logic        md_ready,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic [14:0] pend_mask,
    output logic        pc_pend
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    q_entry_t        head;
    q_entry_t        push_dat;
    logic            q_full;
    logic            q_empty;
    logic [15:0]     q_pend;
    logic            head_valid;
    logic            force_head;
    logic            grant_head;
    logic            grant_wb;
    logic            wr_vld;
    logic [3:0]      wr_wa;
    logic [31:0]     wr_wd;
    logic            push;
    logic            pop;
    logic [SW-1:0]   starve_cnt;

    assign push_dat   = '{valid: 1'b1, wa: md_wa, wd: md_wd};
    assign md_ready   = !reset && !q_full;
    assign push       = md_valid && md_ready;
    assign head_valid = !q_empty && head.valid;
    assign force_head = head_valid && (starve_cnt >= SW'(STARVE_LIMIT));

    always_comb begin
        grant_head = 1'b0;
        grant_wb   = 1'b0;
        if (!reset) begin
            if (force_head) begin
                grant_head = 1'b1;
            end else if (wb_we) begin
                grant_wb   = 1'b1;
            end else if (head_valid) begin
                grant_head = 1'b1;
            end
        end
    end

    assign wb_stall = !reset && force_head && wb_we;
    assign wr_vld   = grant_head || grant_wb;
    assign wr_wa    = grant_head ? head.wa : wb_wa;
    assign wr_wd    = grant_head ? head.wd : wb_wd;
    assign rf_we    = wr_vld && (wr_wa != ADDR_PC);
    assign pc_we    = wr_vld && (wr_wa == ADDR_PC);
    assign rf_wa    = wr_wa;
    assign rf_wd    = wr_wd;
    assign pc_wd    = wr_wd;

    // A squashed head is drained immediately without using the write port.
    assign pop = !reset && !q_empty && (grant_head || !head.valid);

    assign pend_mask = q_pend[14:0];
    assign pc_pend   = q_pend[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_head || !head_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    rf_wr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_vld   (push),
        .push_dat   (push_dat),
        .pop        (pop),
        .squash_vld (grant_wb),
        .squash_wa  (wb_wa),
        .full       (q_full),
        .empty      (q_empty),
        .head_dat   (head),
        .pend_mask  (q_pend)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs driven at negedge, outputs checked 1 time unit later.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        md_valid;
    logic [3:0]  md_wa;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        wb_stall;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [14:0] pend_mask;
    logic        pc_pend;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .md_valid  (md_valid),
        .md_wa     (md_wa),
        .md_wd     (md_wd),
        .md_ready  (md_ready),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd),
        .pend_mask (pend_mask),
        .pc_pend   (pc_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [3:0] wa, input logic [31:0] wd);
        wb_we = we;
        wb_wa = wa;
        wb_wd = wd;
    endtask

    task automatic md(input logic v, input logic [3:0] wa, input logic [31:0] wd);
        md_valid = v;
        md_wa    = wa;
        md_wd    = wd;
    endtask

    initial begin
        reset = 1'b1;
        wb(1'b0, 4'd0, 32'd0);
        md(1'b0, 4'd0, 32'd0);

        // reset holds all enables low even with requests present
        @(negedge clk); wb(1'b1, 4'd3, 32'h55); md(1'b1, 4'd4, 32'h66); #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_md_ready", md_ready, 0);
        @(negedge clk); reset = 1'b0; wb(1'b0, 4'd0, 32'd0); md(1'b0, 4'd0, 32'd0); #1;
        chk("post_rst_pend", pend_mask, 0);
        chk("post_rst_md_ready", md_ready, 1);
        chk("post_rst_rf_we", rf_we, 0);

        // plain writeback
        @(negedge clk); wb(1'b1, 4'd3, 32'h1234); #1;
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_wa", rf_wa, 3);
        chk("wb_rf_wd", rf_wd, 32'h1234);
        chk("wb_stall0", wb_stall, 0);

        // MDU push, written the next cycle
        @(negedge clk); wb(1'b0, 4'd0, 32'd0); md(1'b1, 4'd5, 32'hAA); #1;
        chk("md5_push_ready", md_ready, 1);
        chk("md5_push_no_wr", rf_we, 0);
        @(negedge clk); md(1'b0, 4'd0, 32'd0); #1;
        chk("md5_pend", pend_mask, 32'h20);
        chk("md5_rf_we", rf_we, 1);
        chk("md5_rf_wa", rf_wa, 5);
        chk("md5_rf_wd", rf_wd, 32'hAA);
        @(negedge clk); #1;
        chk("md5_pend_clr", pend_mask, 0);
        chk("md5_idle", rf_we, 0);

        // starvation: head denied 4 cycles, forced on the 5th
        @(negedge clk); md(1'b1, 4'd7, 32'h77); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); md(1'b0, 4'd0, 32'd0); wb(1'b1, 4'd2, 32'h22); #1;
            chk("starve_wb_wa", rf_wa, 2);
            chk("starve_wb_stall", wb_stall, 0);
        end
        @(negedge clk); #1;
        chk("force_stall", wb_stall, 1);
        chk("force_rf_we", rf_we, 1);
        chk("force_rf_wa", rf_wa, 7);
        chk("force_rf_wd", rf_wd, 32'h77);
        @(negedge clk); #1;
        chk("after_force_stall", wb_stall, 0);
        chk("after_force_wa", rf_wa, 2);
        chk("after_force_pend", pend_mask, 0);

        // write-after-write squash
        @(negedge clk); wb(1'b0, 4'd0, 32'd0); md(1'b1, 4'd9, 32'h99); #1;
        @(negedge clk); md(1'b0, 4'd0, 32'd0); wb(1'b1, 4'd9, 32'h909); #1;
        chk("sq_pend9", pend_mask, 32'h200);
        chk("sq_wb_wa", rf_wa, 9);
        chk("sq_wb_wd", rf_wd, 32'h909);
        chk("sq_wb_stall", wb_stall, 0);
        @(negedge clk); wb(1'b0, 4'd0, 32'd0); #1;
        chk("sq_drain_rf_we", rf_we, 0);
        chk("sq_drain_pc_we", pc_we, 0);
        chk("sq_pend_clr", pend_mask, 0);

        // full queue with writeback busy
        @(negedge clk); wb(1'b1, 4'd1, 32'h11); md(1'b1, 4'd10, 32'hA0); #1;
        chk("full_c0_ready", md_ready, 1);
        @(negedge clk); md(1'b1, 4'd11, 32'hB0); #1;
        chk("full_c1_ready", md_ready, 1);
        @(negedge clk); md(1'b1, 4'd12, 32'hC0); #1;
        chk("full_c2_ready", md_ready, 0);
        chk("full_c2_pend", pend_mask, 32'h0C00);
        @(negedge clk); #1;
        chk("full_c3_ready", md_ready, 0);
        @(negedge clk); #1;
        chk("full_c4_ready", md_ready, 0);
        @(negedge clk); #1;
        chk("full_c5_stall", wb_stall, 1);
        chk("full_c5_wa", rf_wa, 10);
        chk("full_c5_ready", md_ready, 0);
        @(negedge clk); #1;
        chk("full_c6_ready", md_ready, 1);
        chk("full_c6_wa", rf_wa, 1);
        chk("full_c6_pend", pend_mask, 32'h0800);
        @(negedge clk); md(1'b0, 4'd0, 32'd0); wb(1'b0, 4'd0, 32'd0); #1;
        chk("full_c7_ready", md_ready, 0);
        chk("full_c7_pend", pend_mask, 32'h1800);
        chk("full_c7_wa", rf_wa, 11);
        chk("full_c7_wd", rf_wd, 32'hB0);
        @(negedge clk); #1;
        chk("full_c8_wa", rf_wa, 12);
        chk("full_c8_wd", rf_wd, 32'hC0);
        @(negedge clk); #1;
        chk("full_c9_rf_we", rf_we, 0);
        chk("full_c9_pend", pend_mask, 0);

        // PC-destination result
        @(negedge clk); md(1'b1, 4'd15, 32'h100); #1;
        @(negedge clk); md(1'b0, 4'd0, 32'd0); #1;
        chk("pc_pend_set", pc_pend, 1);
        chk("pc_we", pc_we, 1);
        chk("pc_wd", pc_wd, 32'h100);
        chk("pc_rf_we", rf_we, 0);
        chk("pc_pend_mask", pend_mask, 0);
        @(negedge clk); #1;
        chk("pc_pend_clr", pc_pend, 0);
        chk("pc_we_clr", pc_we, 0);

        // reset with two entries queued
        @(negedge clk); wb(1'b1, 4'd1, 32'h11); md(1'b1, 4'd3, 32'h33); #1;
        @(negedge clk); md(1'b1, 4'd4, 32'h44); #1;
        @(negedge clk); md(1'b0, 4'd0, 32'd0); reset = 1'b1; #1;
        chk("mid_rst_pend", pend_mask, 32'h18);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_pc_we", pc_we, 0);
        chk("mid_rst_stall", wb_stall, 0);
        chk("mid_rst_ready", md_ready, 0);
        @(negedge clk); reset = 1'b0; wb(1'b0, 4'd0, 32'd0); #1;
        chk("after_rst_pend", pend_mask, 0);
        chk("after_rst_rf_we", rf_we, 0);
        chk("after_rst_ready", md_ready, 1);
        @(negedge clk); #1;
        chk("after_rst_idle", rf_we, 0);
        chk("after_rst_pc_idle", pc_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
